// File: rtl/instruction_fetch.sv
// Fetch stage feeding the decoder: owns the PC, drives a 1-cycle-latency ROM and
// registers the opcode/addressing-mode/operand fields, with stall, branch and HALT.
module instruction_fetch #(
  parameter int unsigned         PC_WIDTH    = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter logic [4:0]          HALT_OPCODE = 5'b11111
) (
  input  logic                ClockInput,
  input  logic                ResetInput,
  output logic [PC_WIDTH-1:0] InstrAddress,
  input  logic [21:0]         InstrData,
  input  logic                StallInput,
  input  logic                BranchTaken,
  input  logic [PC_WIDTH-1:0] BranchTarget,
  output logic [4:0]          OpecodeOutput,
  output logic                AddressingModeOutput,
  output logic [15:0]         OperandOutput,
  output logic [PC_WIDTH-1:0] PcOutput,
  output logic                ValidOutput,
  output logic                HaltOutput
);

  typedef enum logic {StRun, StHalt} state_e;

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                fetch_valid_q, fetch_valid_d;
  logic [4:0]          opcode_q, opcode_d;
  logic                am_q, am_d;
  logic [15:0]         operand_q, operand_d;
  logic [PC_WIDTH-1:0] pc_out_q, pc_out_d;
  logic                valid_q, valid_d;
  logic                halt_q, halt_d;

  // Stall and halt re-read FetchPc so InstrData stays paired with fetch_pc_q.
  always_comb begin
    if (state_q == StHalt) begin
      InstrAddress = fetch_pc_q;
    end else if (BranchTaken) begin
      InstrAddress = BranchTarget;
    end else if (StallInput) begin
      InstrAddress = fetch_pc_q;
    end else begin
      InstrAddress = pc_q;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    opcode_d      = opcode_q;
    am_d          = am_q;
    operand_d     = operand_q;
    pc_out_d      = pc_out_q;
    valid_d       = valid_q;
    halt_d        = halt_q;
    unique case (state_q)
      StRun: begin
        if (BranchTaken) begin
          // Branch squashes the in-flight word, including a pending HALT.
          valid_d       = 1'b0;
          fetch_pc_d    = BranchTarget;
          fetch_valid_d = 1'b1;
          pc_d          = BranchTarget + 1'b1;
        end else if (!StallInput) begin
          opcode_d      = InstrData[21:17];
          am_d          = InstrData[16];
          operand_d     = InstrData[15:0];
          pc_out_d      = fetch_pc_q;
          valid_d       = fetch_valid_q;
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b1;
          pc_d          = pc_q + 1'b1;
          if (fetch_valid_q && (InstrData[21:17] == HALT_OPCODE)) begin
            state_d = StHalt;
            halt_d  = 1'b1;
          end
        end
      end
      StHalt: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge ClockInput or posedge ResetInput) begin
    if (ResetInput) begin
      state_q       <= StRun;
      pc_q          <= RESET_PC;
      fetch_pc_q    <= RESET_PC;
      fetch_valid_q <= 1'b0;
      opcode_q      <= '0;
      am_q          <= 1'b0;
      operand_q     <= '0;
      pc_out_q      <= '0;
      valid_q       <= 1'b0;
      halt_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      opcode_q      <= opcode_d;
      am_q          <= am_d;
      operand_q     <= operand_d;
      pc_out_q      <= pc_out_d;
      valid_q       <= valid_d;
      halt_q        <= halt_d;
    end
  end

  assign OpecodeOutput        = opcode_q;
  assign AddressingModeOutput = am_q;
  assign OperandOutput        = operand_q;
  assign PcOutput             = pc_out_q;
  assign ValidOutput          = valid_q;
  assign HaltOutput           = halt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized stall/branch traffic
// checked against a transaction-level model of which ROM word each edge presents.
module tb_instruction_fetch;

  logic        ClockInput = 1'b0;
  logic        ResetInput;
  logic [7:0]  InstrAddress;
  logic [21:0] InstrData;
  logic        StallInput;
  logic        BranchTaken;
  logic [7:0]  BranchTarget;
  logic [4:0]  OpecodeOutput;
  logic        AddressingModeOutput;
  logic [15:0] OperandOutput;
  logic [7:0]  PcOutput;
  logic        ValidOutput;
  logic        HaltOutput;

  instruction_fetch #(
    .PC_WIDTH   (8),
    .RESET_PC   (8'h00),
    .HALT_OPCODE(5'b11111)
  ) dut (
    .ClockInput          (ClockInput),
    .ResetInput          (ResetInput),
    .InstrAddress        (InstrAddress),
    .InstrData           (InstrData),
    .StallInput          (StallInput),
    .BranchTaken         (BranchTaken),
    .BranchTarget        (BranchTarget),
    .OpecodeOutput       (OpecodeOutput),
    .AddressingModeOutput(AddressingModeOutput),
    .OperandOutput       (OperandOutput),
    .PcOutput            (PcOutput),
    .ValidOutput         (ValidOutput),
    .HaltOutput          (HaltOutput)
  );

  always #5 ClockInput = ~ClockInput;

  logic [21:0] rom [256];
  always @(posedge ClockInput) InstrData <= rom[InstrAddress];

  int checks = 0;
  int failures = 0;

  // Model: next address to issue, word on the ROM bus, word presented, halted flag.
  logic [7:0] m_pc, m_bus_pc, m_out_pc;
  bit         m_bus_v, m_out_v, m_halt;

  task automatic model_reset();
    m_pc = 8'h00; m_bus_pc = 8'h00; m_out_pc = 8'h00;
    m_bus_v = 1'b0; m_out_v = 1'b0; m_halt = 1'b0;
  endtask

  task automatic model_edge();
    if (m_halt) begin
      m_out_v = 1'b0;
    end else if (BranchTaken) begin
      m_out_v = 1'b0;
      m_bus_pc = BranchTarget; m_bus_v = 1'b1; m_pc = BranchTarget + 8'd1;
    end else if (!StallInput) begin
      m_out_v = m_bus_v; m_out_pc = m_bus_pc;
      if (m_bus_v && rom[m_bus_pc][21:17] == 5'h1F) m_halt = 1'b1;
      m_bus_pc = m_pc; m_bus_v = 1'b1; m_pc = m_pc + 8'd1;
    end
  endtask

  function automatic logic [7:0] exp_addr();
    if (m_halt) return m_bus_pc;
    if (BranchTaken) return BranchTarget;
    if (StallInput) return m_bus_pc;
    return m_pc;
  endfunction

  task automatic tick();
    @(posedge ClockInput);
    if (!ResetInput) model_edge();
    @(negedge ClockInput);
  endtask

  task automatic fill_rom();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      logic [4:0] op;
      a = i[7:0];
      op = (a[4:0] == 5'h1F) ? 5'h00 : a[4:0];
      rom[i] = {op, a[0], 16'h1000 + {8'h00, a}};
    end
  endtask

  task automatic apply_reset();
    ResetInput = 1'b1; StallInput = 1'b0; BranchTaken = 1'b0; BranchTarget = 8'h00;
    model_reset();
    @(negedge ClockInput);
    ResetInput = 1'b0;
  endtask

  task automatic test_reset();
    ResetInput = 1'b1; StallInput = 1'b0; BranchTaken = 1'b0; BranchTarget = 8'h00;
    model_reset();
    @(negedge ClockInput);
    #1;
    checks++; if (ValidOutput !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", ValidOutput); end
    checks++; if (HaltOutput !== 1'b0) begin failures++; $display("FAIL reset_halt got=%0b exp=0", HaltOutput); end
    checks++; if (PcOutput !== 8'h00) begin failures++; $display("FAIL reset_pc got=%0h exp=0", PcOutput); end
    checks++; if ({OpecodeOutput, AddressingModeOutput, OperandOutput} !== 22'h0) begin
      failures++; $display("FAIL reset_fields got=%0h exp=0", {OpecodeOutput, AddressingModeOutput, OperandOutput});
    end
    checks++; if (InstrAddress !== 8'h00) begin failures++; $display("FAIL reset_addr got=%0h exp=0", InstrAddress); end
    @(negedge ClockInput);
    ResetInput = 1'b0;
  endtask

  task automatic test_sequential();
    tick();
    checks++; if (ValidOutput !== 1'b0) begin failures++; $display("FAIL seq_edge1_valid got=%0b exp=0", ValidOutput); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ValidOutput !== 1'b1 || PcOutput !== k[7:0]) begin
        failures++; $display("FAIL seq_pc got=%0b/%0h exp=1/%0h", ValidOutput, PcOutput, k[7:0]);
      end
      checks++; if (OperandOutput !== 16'h1000 + k[15:0] || OpecodeOutput !== k[4:0]) begin
        failures++; $display("FAIL seq_fields got=%0h/%0h exp=%0h/%0h", OpecodeOutput, OperandOutput, k[4:0], 16'h1000 + k[15:0]);
      end
    end
  endtask

  task automatic test_stall();
    StallInput = 1'b1;
    #1;
    checks++; if (InstrAddress !== 8'h03) begin failures++; $display("FAIL stall_addr0 got=%0h exp=3", InstrAddress); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (PcOutput !== 8'h02 || ValidOutput !== 1'b1 || OperandOutput !== 16'h1002) begin
        failures++; $display("FAIL stall_hold got=%0h/%0b/%0h exp=2/1/1002", PcOutput, ValidOutput, OperandOutput);
      end
      checks++; if (InstrAddress !== 8'h03) begin failures++; $display("FAIL stall_addr got=%0h exp=3", InstrAddress); end
    end
    StallInput = 1'b0;
    for (int k = 3; k < 5; k++) begin
      tick();
      checks++; if (PcOutput !== k[7:0] || ValidOutput !== 1'b1 || OperandOutput !== 16'h1000 + k[15:0]) begin
        failures++; $display("FAIL stall_resume got=%0h/%0b/%0h exp=%0h/1", PcOutput, ValidOutput, OperandOutput, k[7:0]);
      end
    end
  endtask

  task automatic test_branch();
    tick();
    checks++; if (PcOutput !== 8'h05) begin failures++; $display("FAIL br_pre got=%0h exp=5", PcOutput); end
    BranchTaken = 1'b1; BranchTarget = 8'h40;
    #1;
    checks++; if (InstrAddress !== 8'h40) begin failures++; $display("FAIL br_addr got=%0h exp=40", InstrAddress); end
    tick();
    BranchTaken = 1'b0;
    checks++; if (ValidOutput !== 1'b0 || PcOutput !== 8'h05) begin
      failures++; $display("FAIL br_bubble got=%0b/%0h exp=0/5", ValidOutput, PcOutput);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ValidOutput !== 1'b1 || PcOutput !== 8'h40 + k[7:0] || OperandOutput !== 16'h1040 + k[15:0]) begin
        failures++; $display("FAIL br_target got=%0b/%0h/%0h exp=1/%0h", ValidOutput, PcOutput, OperandOutput, 8'h40 + k[7:0]);
      end
    end
  endtask

  task automatic test_branch_stall();
    BranchTaken = 1'b1; StallInput = 1'b1; BranchTarget = 8'h20;
    #1;
    checks++; if (InstrAddress !== 8'h20) begin failures++; $display("FAIL brst_addr got=%0h exp=20", InstrAddress); end
    tick();
    BranchTaken = 1'b0; StallInput = 1'b0;
    checks++; if (ValidOutput !== 1'b0) begin failures++; $display("FAIL brst_bubble got=%0b exp=0", ValidOutput); end
    tick();
    checks++; if (ValidOutput !== 1'b1 || PcOutput !== 8'h20 || OperandOutput !== 16'h1020) begin
      failures++; $display("FAIL brst_target got=%0b/%0h/%0h exp=1/20/1020", ValidOutput, PcOutput, OperandOutput);
    end
  endtask

  task automatic test_halt();
    rom[6] = {5'h1F, 1'b0, 16'h1006};
    apply_reset();
    repeat (7) tick();
    checks++; if (PcOutput !== 8'h05 || HaltOutput !== 1'b0) begin
      failures++; $display("FAIL halt_pre got=%0h/%0b exp=5/0", PcOutput, HaltOutput);
    end
    tick();
    checks++; if (PcOutput !== 8'h06 || ValidOutput !== 1'b1 || HaltOutput !== 1'b1 || OpecodeOutput !== 5'h1F) begin
      failures++; $display("FAIL halt_word got=%0h/%0b/%0b/%0h exp=6/1/1/1f", PcOutput, ValidOutput, HaltOutput, OpecodeOutput);
    end
    BranchTaken = 1'b1; BranchTarget = 8'h00;
    #1;
    checks++; if (InstrAddress !== 8'h07) begin failures++; $display("FAIL halt_addr got=%0h exp=7", InstrAddress); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (ValidOutput !== 1'b0 || HaltOutput !== 1'b1 || PcOutput !== 8'h06 || InstrAddress !== 8'h07) begin
        failures++; $display("FAIL halt_frozen got=%0b/%0b/%0h/%0h exp=0/1/6/7", ValidOutput, HaltOutput, PcOutput, InstrAddress);
      end
    end
    BranchTaken = 1'b0;
    rom[6] = {5'h06, 1'b0, 16'h1006};
    apply_reset();
    tick(); tick();
    checks++; if (ValidOutput !== 1'b1 || PcOutput !== 8'h00 || HaltOutput !== 1'b0) begin
      failures++; $display("FAIL halt_restart got=%0b/%0h/%0b exp=1/0/0", ValidOutput, PcOutput, HaltOutput);
    end
  endtask

  task automatic test_wrap_reset();
    BranchTaken = 1'b1; BranchTarget = 8'hFE;
    tick();
    BranchTaken = 1'b0;
    for (int k = 0; k < 4; k++) begin
      logic [7:0] e;
      e = 8'hFE + k[7:0];
      tick();
      checks++; if (ValidOutput !== 1'b1 || PcOutput !== e || OperandOutput !== 16'h1000 + {8'h00, e}) begin
        failures++; $display("FAIL wrap_pc got=%0b/%0h/%0h exp=1/%0h", ValidOutput, PcOutput, OperandOutput, e);
      end
    end
    StallInput = 1'b1;
    tick();
    #2;
    ResetInput = 1'b1;
    #1;
    checks++; if (ValidOutput !== 1'b0 || PcOutput !== 8'h00 || HaltOutput !== 1'b0 ||
                  {OpecodeOutput, AddressingModeOutput, OperandOutput} !== 22'h0) begin
      failures++; $display("FAIL async_reset got=%0b/%0h/%0b/%0h exp=all zero", ValidOutput, PcOutput, HaltOutput, OperandOutput);
    end
    StallInput = 1'b0;
    @(negedge ClockInput);
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) begin
      logic [4:0] op;
      op = 5'($urandom_range(0, 30));
      rom[i] = {op, 1'($urandom), 16'($urandom)};
    end
    apply_reset();
    for (int n = 0; n < 400; n++) begin
      StallInput = ($urandom_range(0, 3) == 0);
      BranchTaken = ($urandom_range(0, 6) == 0);
      BranchTarget = 8'($urandom);
      #1;
      checks++; if (InstrAddress !== exp_addr()) begin
        failures++; $display("FAIL rnd_addr cyc=%0d got=%0h exp=%0h", n, InstrAddress, exp_addr());
      end
      tick();
      checks++; if (ValidOutput !== m_out_v || HaltOutput !== m_halt) begin
        failures++; $display("FAIL rnd_flags cyc=%0d got=%0b/%0b exp=%0b/%0b", n, ValidOutput, HaltOutput, m_out_v, m_halt);
      end
      if (m_out_v) begin
        checks++; if (PcOutput !== m_out_pc ||
                      {OpecodeOutput, AddressingModeOutput, OperandOutput} !== rom[m_out_pc]) begin
          failures++; $display("FAIL rnd_word cyc=%0d got=%0h/%0h exp=%0h/%0h", n, PcOutput,
                               {OpecodeOutput, AddressingModeOutput, OperandOutput}, m_out_pc, rom[m_out_pc]);
        end
      end
    end
    StallInput = 1'b0; BranchTaken = 1'b0;
  endtask

  initial begin
    ResetInput = 1'b1; StallInput = 1'b0; BranchTaken = 1'b0; BranchTarget = 8'h00;
    fill_rom();
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_stall();
    test_halt();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
